// File: rtl/pipeline_controller_pkg.sv
// Shared constants and FSM encoding for the ARM pipeline sequencer.
package pipeline_controller_pkg;

  localparam int REG_W           = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 255;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// SRAM handshake between the MEM stage, the sequencer and the SRAM controller.
interface pipeline_controller_if;

  logic mem_r_en;
  logic mem_w_en;
  logic mem_ready;
  logic mem_start;

  // Sequencer side: launches accesses and watches for completion.
  modport master (
    input  mem_r_en,
    input  mem_w_en,
    input  mem_ready,
    output mem_start
  );

  // MEM stage / SRAM controller side.
  modport slave (
    output mem_r_en,
    output mem_w_en,
    output mem_ready,
    input  mem_start
  );

endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// RAW hazard check between the ID operands and the EXE/MEM destinations.
// With forwarding only a load in EXE forces a stall; without it any pending
// write-back to an operand register does.
module pipeline_controller_hazard_detect
  import pipeline_controller_pkg::*;
(
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_uses_src1,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);

  logic hit_exe;
  logic hit_mem;

  assign hit_exe = (id_uses_src1 & (id_src1 == exe_dest)) |
                   (id_two_src   & (id_src2 == exe_dest));
  assign hit_mem = (id_uses_src1 & (id_src1 == mem_dest)) |
                   (id_two_src   & (id_src2 == mem_dest));

  assign hazard = fwd_en ? (exe_mem_r_en & exe_wb_en & hit_exe)
                         : ((exe_wb_en & hit_exe) | (mem_wb_en & hit_mem));

endmodule

// File: rtl/pipeline_controller.sv
// Central sequencer for the 5-stage pipeline: SRAM wait FSM, hazard/branch
// freeze-flush priority and a saturating stall-cycle counter.
//
//  state    | meaning
//  IDLE     | no SRAM access in flight; a MEM-stage request launches one
//  MEM_WAIT | access launched, whole pipeline held until ready or timeout
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
)
(
  input  logic                 clk,
  input  logic                 rst,
  pipeline_controller_if.master mem_bus,
  input  logic                 fwd_en,
  input  logic [REG_W-1:0]     id_src1,
  input  logic [REG_W-1:0]     id_src2,
  input  logic                 id_two_src,
  input  logic                 id_uses_src1,
  input  logic [REG_W-1:0]     exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_W-1:0]     mem_dest,
  input  logic                 mem_wb_en,
  input  logic                 branch_taken,
  output logic                 freeze_front,
  output logic                 flush_if_reg,
  output logic                 flush_id_reg,
  output logic                 freeze_all,
  output logic                 mem_error,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hazard;
  logic              req;
  logic              timeout;
  logic              mem_start_c;

  pipeline_controller_hazard_detect u_hazard (
    .fwd_en       (fwd_en),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_uses_src1 (id_uses_src1),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  assign req     = mem_bus.mem_r_en | mem_bus.mem_w_en;
  assign timeout = (state == MEM_WAIT) & ~mem_bus.mem_ready &
                   (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign mem_bus.mem_start = mem_start_c;

  // Output priority: SRAM hold beats branch flush beats hazard bubble; all quiet in reset.
  always_comb begin
    mem_start_c  = 1'b0;
    freeze_all   = 1'b0;
    freeze_front = 1'b0;
    flush_if_reg = 1'b0;
    flush_id_reg = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            mem_start_c = 1'b1;
            freeze_all  = 1'b1;
          end
        end
        MEM_WAIT: freeze_all = ~mem_bus.mem_ready & ~timeout;
        default: ;
      endcase
      if (!freeze_all) begin
        if (branch_taken) begin
          flush_if_reg = 1'b1;
          flush_id_reg = 1'b1;
        end else if (hazard) begin
          freeze_front = 1'b1;
          flush_id_reg = 1'b1;
        end
      end
    end
  end

  // SRAM wait FSM, timeout tracking, sticky error and stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (req) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_bus.mem_ready) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (timeout) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if ((freeze_all | freeze_front) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: per-cycle reference model plus directed literal checks.
module tb_pipeline_controller;
  import pipeline_controller_pkg::*;

  localparam int CNT_W = 6;
  localparam int TMO   = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             fwd_en, id_two_src, id_uses_src1;
  logic [REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic             exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken;
  logic             freeze_front, flush_if_reg, flush_id_reg, freeze_all, mem_error;
  logic [CNT_W-1:0] stall_cycles;

  int n_vec = 0;
  int n_bad = 0;

  pipeline_controller_if bus ();

  pipeline_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_bus      (bus),
    .fwd_en       (fwd_en),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_uses_src1 (id_uses_src1),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .branch_taken (branch_taken),
    .freeze_front (freeze_front),
    .flush_if_reg (flush_if_reg),
    .flush_id_reg (flush_id_reg),
    .freeze_all   (freeze_all),
    .mem_error    (mem_error),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fwd_en = 0; id_two_src = 0; id_uses_src1 = 0;
    id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
    exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0; branch_taken = 0;
    bus.mem_r_en = 0; bus.mem_w_en = 0; bus.mem_ready = 0;
  endtask

  // Reference model: does any operand ID reads have a producer it must wait for?
  function automatic bit model_hazard();
    bit hit_e, hit_m;
    hit_e = (id_uses_src1 && id_src1 == exe_dest) || (id_two_src && id_src2 == exe_dest);
    hit_m = (id_uses_src1 && id_src1 == mem_dest) || (id_two_src && id_src2 == mem_dest);
    if (fwd_en) return exe_mem_r_en && exe_wb_en && hit_e;
    return (exe_wb_en && hit_e) || (mem_wb_en && hit_m);
  endfunction

  // Model state: cycles already waited on the access in flight (-1: none).
  int m_wait  = -1;
  bit m_err   = 0;
  int m_stall = 0;

  always @(negedge clk) begin
    bit e_start, e_fa, e_ff, e_fif, e_fid, req;
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("mem_error", 32'(mem_error), 32'(m_err));
    e_start = 0; e_fa = 0; e_ff = 0; e_fif = 0; e_fid = 0;
    req = bus.mem_r_en || bus.mem_w_en;
    if (rst) begin
      if (m_wait < 0) begin
        e_start = req;
        e_fa    = req;
      end else begin
        e_fa = !bus.mem_ready && (m_wait < TMO);
      end
      if (!e_fa) begin
        if (branch_taken) begin
          e_fif = 1; e_fid = 1;
        end else if (model_hazard()) begin
          e_ff = 1; e_fid = 1;
        end
      end
    end
    chk("mem_start", 32'(bus.mem_start), 32'(e_start));
    chk("freeze_all", 32'(freeze_all), 32'(e_fa));
    chk("freeze_front", 32'(freeze_front), 32'(e_ff));
    chk("flush_if_reg", 32'(flush_if_reg), 32'(e_fif));
    chk("flush_id_reg", 32'(flush_id_reg), 32'(e_fid));
    if (!rst) begin
      m_wait = -1; m_err = 0; m_stall = 0;
    end else begin
      if ((e_fa || e_ff) && m_stall < SAT) m_stall++;
      if (m_wait < 0) begin
        if (req) m_wait = 0;
      end else if (bus.mem_ready) begin
        m_wait = -1;
      end else if (m_wait == TMO) begin
        m_err = 1; m_wait = -1;
      end else begin
        m_wait++;
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 0;
    bus.mem_r_en = 1;
    // Reset holds everything quiet even with a memory request present.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      chk("rst_freeze_all", 32'(freeze_all), 0);
      chk("rst_mem_start", 32'(bus.mem_start), 0);
      chk("rst_stall", 32'(stall_cycles), 0);
    end
    next_cycle();
    rst = 1;
    clear_inputs();

    // Load-use with forwarding: one-cycle bubble.
    fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3;
    id_uses_src1 = 1; id_src1 = 3;
    @(negedge clk);
    chk("lu_freeze_front", 32'(freeze_front), 1);
    chk("lu_flush_id", 32'(flush_id_reg), 1);
    chk("lu_flush_if", 32'(flush_if_reg), 0);
    next_cycle();
    exe_mem_r_en = 0;
    @(negedge clk);
    chk("fwd_alu_no_stall", 32'(freeze_front), 0);
    chk("fwd_alu_no_flush", 32'(flush_id_reg), 0);
    next_cycle();

    // No forwarding: MEM-stage producer on src2.
    clear_inputs();
    mem_wb_en = 1; mem_dest = 5; id_two_src = 1; id_src2 = 5;
    @(negedge clk);
    chk("nofwd_mem_hazard", 32'(freeze_front), 1);
    next_cycle();
    id_two_src = 0;
    @(negedge clk);
    chk("nofwd_src2_unused", 32'(freeze_front), 0);
    next_cycle();
    id_two_src = 1; fwd_en = 1;
    @(negedge clk);
    chk("fwd_mem_no_stall", 32'(freeze_front), 0);
    next_cycle();
    // Branch beats hazard.
    fwd_en = 0; branch_taken = 1;
    @(negedge clk);
    chk("br_over_hz_ff", 32'(freeze_front), 0);
    chk("br_over_hz_fif", 32'(flush_if_reg), 1);
    chk("br_over_hz_fid", 32'(flush_id_reg), 1);
    next_cycle();

    // Mixed hazard/branch patterns, checked by the model.
    clear_inputs();
    for (int i = 0; i < 40; i++) begin
      fwd_en       = 1'($urandom_range(0, 1));
      id_uses_src1 = 1'($urandom_range(0, 1));
      id_two_src   = 1'($urandom_range(0, 1));
      id_src1      = REG_W'($urandom_range(0, 3));
      id_src2      = REG_W'($urandom_range(0, 3));
      exe_dest     = REG_W'($urandom_range(0, 3));
      mem_dest     = REG_W'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_wb_en    = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      next_cycle();
    end

    // SRAM write, ready four cycles after launch.
    clear_inputs();
    rst = 0;
    next_cycle();
    rst = 1;
    bus.mem_w_en = 1;
    @(negedge clk);
    chk("wr_start", 32'(bus.mem_start), 1);
    chk("wr_freeze0", 32'(freeze_all), 1);
    next_cycle();
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("wr_no_restart", 32'(bus.mem_start), 0);
      chk("wr_freeze", 32'(freeze_all), 1);
      next_cycle();
    end
    bus.mem_ready = 1;
    @(negedge clk);
    chk("wr_ready_release", 32'(freeze_all), 0);
    next_cycle();
    bus.mem_ready = 0; bus.mem_w_en = 0;
    @(negedge clk);
    chk("wr_stall_count", 32'(stall_cycles), 4);
    next_cycle();

    // Branch while frozen flushes only on the release cycle.
    bus.mem_r_en = 1;
    @(negedge clk);
    chk("brf_start", 32'(bus.mem_start), 1);
    next_cycle();
    branch_taken = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("brf_held_fif", 32'(flush_if_reg), 0);
      chk("brf_held_fid", 32'(flush_id_reg), 0);
      next_cycle();
    end
    bus.mem_ready = 1;
    @(negedge clk);
    chk("brf_rel_fif", 32'(flush_if_reg), 1);
    chk("brf_rel_fid", 32'(flush_id_reg), 1);
    chk("brf_rel_fa", 32'(freeze_all), 0);
    next_cycle();
    clear_inputs();

    // mem_ready in IDLE does not complete anything.
    bus.mem_ready = 1;
    @(negedge clk);
    chk("idle_ready_fa", 32'(freeze_all), 0);
    next_cycle();
    bus.mem_r_en = 1;
    @(negedge clk);
    chk("idle_ready_launch", 32'(bus.mem_start), 1);
    next_cycle();
    bus.mem_ready = 0;
    @(negedge clk);
    chk("idle_ready_still_wait", 32'(freeze_all), 1);
    next_cycle();
    bus.mem_ready = 1;
    next_cycle();
    clear_inputs();

    // Timeout: never ready.
    bus.mem_r_en = 1;
    @(negedge clk);
    chk("to_start", 32'(bus.mem_start), 1);
    next_cycle();
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      chk("to_waiting", 32'(freeze_all), 1);
      next_cycle();
    end
    bus.mem_r_en = 0;
    @(negedge clk);
    chk("to_release", 32'(freeze_all), 0);
    chk("to_err_not_yet", 32'(mem_error), 0);
    next_cycle();
    @(negedge clk);
    chk("to_err_set", 32'(mem_error), 1);
    next_cycle();
    bus.mem_w_en = 1;
    next_cycle();
    bus.mem_ready = 1;
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("to_err_sticky", 32'(mem_error), 1);
    next_cycle();
    rst = 0;
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("to_err_cleared", 32'(mem_error), 0);
    next_cycle();

    // Reset in MEM_WAIT, then a stray ready.
    bus.mem_r_en = 1;
    next_cycle();
    rst = 0;
    next_cycle();
    rst = 1; bus.mem_r_en = 0; bus.mem_ready = 1;
    @(negedge clk);
    chk("rstw_fa", 32'(freeze_all), 0);
    chk("rstw_start", 32'(bus.mem_start), 0);
    next_cycle();
    clear_inputs();

    // Stall counter saturates without wrapping.
    rst = 0;
    next_cycle();
    rst = 1;
    exe_wb_en = 1; exe_dest = 1; id_uses_src1 = 1; id_src1 = 1;
    repeat (SAT + 7) next_cycle();
    @(negedge clk);
    chk("stall_saturated", 32'(stall_cycles), SAT);
    next_cycle();
    clear_inputs();
    next_cycle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
